sram_rr_arbiter: RTL and testbench
==================================

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
- REQ-001: Parameter NumReq, default 32'd2: number of requesters; SHALL be >= 1.
- REQ-002: Parameter NumWords, default 32'd1024: words in the attached SRAM.
- REQ-003: Parameter DataWidth, default 32'd64: data width.
- REQ-004: Parameter ByteWidth, default 32'd8: byte width; BeWidth = ceil(DataWidth/ByteWidth).
- REQ-005: Parameter Latency, default 32'd1: SRAM read latency in cycles; SHALL be >= 1.
- REQ-006: Derived AddrWidth = (NumWords > 1) ? clog2(NumWords) : 1; IdxWidth = (NumReq > 1) ? clog2(NumReq) : 1.
- REQ-007: clk_i  input  1  clock; the single clock; all state on rising edge.
- REQ-008: rst_ni  input  1  reset; asynchronous, active-low.
- REQ-009: req_valid_i  input  NumReq  per-requester request valid.
- REQ-010: req_ready_o  output  NumReq  per-requester grant/accept.
- REQ-011: req_we_i  input  NumReq  write enable per requester.
- REQ-012: req_addr_i  input  NumReq x AddrWidth  word address per requester.
- REQ-013: req_wdata_i  input  NumReq x DataWidth  write data per requester.
- REQ-014: req_be_i  input  NumReq x BeWidth  byte enables per requester.
- REQ-015: rsp_valid_o  output  NumReq  read data valid, one-hot or zero.
- REQ-016: rsp_rdata_o  output  DataWidth  read data, shared by all requesters.
- REQ-017: sram_req_o / sram_we_o  output  1 each  SRAM request / write enable.
- REQ-018: sram_addr_o / sram_wdata_o / sram_be_o  output  AddrWidth / DataWidth / BeWidth  SRAM payload.
- REQ-019: sram_rdata_i  input  DataWidth  SRAM read data, valid Latency cycles after a read request.

Function
- REQ-020: Transfer on port i SHALL occur when req_valid_i[i] and req_ready_o[i] are both high at a rising edge.
- REQ-021: At most one req_ready_o bit SHALL be high per cycle; req_ready_o SHALL be zero when no req_valid_i bit is high.
- REQ-022: Round-robin: the grantee SHALL be the first i with req_valid_i[i] high, searching from rr_ptr upward modulo NumReq.
- REQ-023: rr_ptr SHALL become (grantee+1) mod NumReq after each transfer and hold otherwise; wrap from NumReq-1 to 0.
- REQ-024: Grant SHALL be combinational from req_valid_i and rr_ptr; no bubble cycles, one transfer per cycle sustained.
- REQ-025: sram_req_o SHALL equal OR of req_valid_i; sram_we/addr/wdata/be SHALL mux the grantee's inputs; all SRAM payload outputs SHALL be zero when idle.
- REQ-026: Each granted read SHALL push {valid=1, idx=grantee} into a Latency-deep shift register; writes and idle cycles push valid=0.
- REQ-027: rsp_valid_o[idx] SHALL assert exactly Latency cycles after the read transfer, for one cycle, and rsp_rdata_o SHALL equal sram_rdata_i in that cycle.
- REQ-028: Writes SHALL produce no response; back-to-back reads from different ports SHALL return in issue order, one per cycle.
- REQ-029: rsp_rdata_o SHALL pass sram_rdata_i through unconditionally; content is undefined when rsp_valid_o is zero.
- REQ-030: NumReq = 1: req_ready_o SHALL equal req_valid_i; rr_ptr is constant 0.
- REQ-031: Addresses SHALL be forwarded unchanged; out-of-range addresses are not checked by this block.
- REQ-032: Requester rule (asserted in simulation): once req_valid_i[i] rises, it and the payload SHALL stay stable until transfer.

Reset
- REQ-033: On rst_ni low, rr_ptr SHALL be 0 and all shift-register valid bits 0, asynchronously.
- REQ-034: During and after reset, rsp_valid_o SHALL be all-zero until a new read completes; in-flight reads at reset SHALL be dropped.
- REQ-035: req_ready_o and sram_req_o remain combinational during reset; the SRAM is not reset by this block.

Verification (NumReq=3, Latency=2, DataWidth=32)
- REQ-036: All three valid from reset, reads to 0x10/0x20/0x30 -> grants in order 0,1,2,0; rsp_valid_o = 001,010,100 at cycles 2,3,4.
- REQ-037: Port 1 writes 0xDEADBEEF, be=4'hF, to 0x5; next cycle port 2 reads 0x5 -> no write response; rsp_valid_o=100 two cycles later with rsp_rdata_o=0xDEADBEEF.
- REQ-038: rr_ptr=2, only port 0 valid -> grant port 0 same cycle, rr_ptr becomes 1 (wrap check).
- REQ-039: Port 0 read granted, rst_ni pulsed low next cycle -> rsp_valid_o stays 000; after release first grant goes to port 0.
- REQ-040: Idle cycle with no valid -> sram_req_o=0, sram_we_o=0, sram_addr_o=0, req_ready_o=000, rr_ptr unchanged.

Source files
------------

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for sram_rr_arbiter.
// slave is the arbiter; master is the requesters together with the attached SRAM.
interface sram_rr_arbiter_if #(
  parameter int unsigned NumReq    = 32'd2,
  parameter int unsigned NumWords  = 32'd1024,
  parameter int unsigned DataWidth = 32'd64,
  parameter int unsigned ByteWidth = 32'd8
);
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;

  logic [NumReq-1:0]                req_valid_i;
  logic [NumReq-1:0]                req_ready_o;
  logic [NumReq-1:0]                req_we_i;
  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i;
  logic [NumReq-1:0][BeWidth-1:0]   req_be_i;
  logic [NumReq-1:0]                rsp_valid_o;
  logic [DataWidth-1:0]             rsp_rdata_o;
  logic                             sram_req_o;
  logic                             sram_we_o;
  logic [AddrWidth-1:0]             sram_addr_o;
  logic [DataWidth-1:0]             sram_wdata_o;
  logic [BeWidth-1:0]               sram_be_o;
  logic [DataWidth-1:0]             sram_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters;
// read responses are routed back through a Latency-deep tag pipeline.
module sram_rr_arbiter #(
  parameter int unsigned NumReq    = 32'd2,
  parameter int unsigned NumWords  = 32'd1024,
  parameter int unsigned DataWidth = 32'd64,
  parameter int unsigned ByteWidth = 32'd8,
  parameter int unsigned Latency   = 32'd1
) (
  input logic              clk_i,
  input logic              rst_ni,
  sram_rr_arbiter_if.slave bus
);
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;
  localparam int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CandWidth = IdxWidth + 1;

  localparam logic [CandWidth-1:0] NumReqC = CandWidth'(NumReq);
  localparam logic [IdxWidth-1:0]  LastIdx = IdxWidth'(NumReq - 1);

  logic [IdxWidth-1:0]  rr_ptr;
  logic                 gnt_found;
  logic [IdxWidth-1:0]  gnt_idx;
  logic [CandWidth-1:0] cand;

  logic                 gnt_we;
  logic [AddrWidth-1:0] gnt_addr;
  logic [DataWidth-1:0] gnt_wdata;
  logic [BeWidth-1:0]   gnt_be;

  logic                 pipe_valid [Latency];
  logic [IdxWidth-1:0]  pipe_idx   [Latency];

  // Search upward from rr_ptr; cand carries one spare bit so the wrap is a single subtract.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path can infer a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      // NOTE: blocking assignments here, since cand is recomputed and read within each iteration.
      cand = {1'b0, rr_ptr} + CandWidth'(k);
      if (cand >= NumReqC) cand = cand - NumReqC;
      if (!gnt_found && bus.req_valid_i[cand[IdxWidth-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdxWidth-1:0];
      end
    end
  end

  always_comb begin
    gnt_we    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_be    = '0;
    if (gnt_found) begin
      gnt_we    = bus.req_we_i[gnt_idx];
      gnt_addr  = bus.req_addr_i[gnt_idx];
      gnt_wdata = bus.req_wdata_i[gnt_idx];
      gnt_be    = bus.req_be_i[gnt_idx];
    end
  end

  assign bus.sram_req_o   = |bus.req_valid_i;
  assign bus.sram_we_o    = gnt_we;
  assign bus.sram_addr_o  = gnt_addr;
  assign bus.sram_wdata_o = gnt_wdata;
  assign bus.sram_be_o    = gnt_be;
  assign bus.rsp_rdata_o  = bus.sram_rdata_i;

  always_comb begin
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      bus.req_ready_o[i] = gnt_found && (gnt_idx == IdxWidth'(i));
      bus.rsp_valid_o[i] = pipe_valid[Latency-1] && (pipe_idx[Latency-1] == IdxWidth'(i));
    end
  end

  // A grant is always a transfer, because ready is only raised for a valid requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking for all clocked state, so every register samples pre-edge values.
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (gnt_found) begin
      rr_ptr <= (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < Latency; s++) pipe_valid[s] <= 1'b0;
    end else begin
      pipe_valid[0] <= gnt_found && !gnt_we;
      for (int unsigned s = 1; s < Latency; s++) pipe_valid[s] <= pipe_valid[s-1];
    end
  end

  // NOTE: the tag stages are left unreset; they are only consumed under their reset-cleared valid bit.
  always_ff @(posedge clk_i) begin
    pipe_idx[0] <= gnt_idx;
    for (int unsigned s = 1; s < Latency; s++) pipe_idx[s] <= pipe_idx[s-1];
  end

  // A requester that is kept waiting must hold its request and payload.
  for (genvar i = 0; i < NumReq; i++) begin : g_req_stable
    a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.req_valid_i[i] && !bus.req_ready_o[i]) |=>
        (bus.req_valid_i[i] && $stable(bus.req_we_i[i]) && $stable(bus.req_addr_i[i]) &&
         $stable(bus.req_wdata_i[i]) && $stable(bus.req_be_i[i])));
  end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter with 3 requesters, 2-cycle SRAM, 32-bit data: directed
// vectors, reset/write corner sequences, then random traffic against a queue-based model.
module tb_sram_rr_arbiter;
  localparam int unsigned NR  = 3;
  localparam int unsigned NW  = 1024;
  localparam int unsigned DW  = 32;
  localparam int unsigned BYW = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 10;
  localparam int unsigned BW  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_rr_arbiter_if #(.NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(BYW)) bus ();

  sram_rr_arbiter #(
    .NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(BYW), .Latency(LAT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] pattern(input int a);
    return 32'hA000_0000 | DW'(a);
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Attached SRAM: byte-enabled writes, reads return LAT cycles after the request.
  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] rd_pipe [LAT];
  logic          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < int'(NW); a++) mem[a] <= pattern(a);
      mem_init <= 1'b1;
    end else if (bus.sram_req_o && bus.sram_we_o) begin
      for (int b = 0; b < int'(BW); b++)
        if (bus.sram_be_o[b]) mem[bus.sram_addr_o][b*8 +: 8] <= bus.sram_wdata_o[b*8 +: 8];
    end
    rd_pipe[0] <= (bus.sram_req_o && !bus.sram_we_o) ? mem[bus.sram_addr_o] : '0;
    for (int s = 1; s < int'(LAT); s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign bus.sram_rdata_i = rd_pipe[LAT-1];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Requester stimulus, kept locally and copied onto the bus.
  logic [NR-1:0] s_valid, s_we;
  logic [AW-1:0] s_addr  [NR];
  logic [DW-1:0] s_wdata [NR];
  logic [BW-1:0] s_be    [NR];

  task automatic drive();
    bus.req_valid_i = s_valid;
    bus.req_we_i    = s_we;
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_addr_i[i]  = s_addr[i];
      bus.req_wdata_i[i] = s_wdata[i];
      bus.req_be_i[i]    = s_be[i];
    end
  endtask

  task automatic clear_ports();
    s_valid = '0;
    s_we    = '0;
    for (int i = 0; i < int'(NR); i++) begin
      s_addr[i]  = '0;
      s_wdata[i] = '0;
      s_be[i]    = '0;
    end
    drive();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
    logic [AW-1:0] exp_addr;
    logic [NR-1:0] exp_rsp;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vec [12];

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  logic [DW-1:0] ref_mem [16];
  logic [NR-1:0] held;
  logic [NR-1:0] exp_ready, exp_rsp;
  int            ptr, cyc, g, j, ra;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // All reads; port i always targets 0x10*(i+1) so data is known from the SRAM pattern.
    vec[0]  = '{3'b111, 3'b001, 10'h010, 3'b000, 32'h0};
    vec[1]  = '{3'b110, 3'b010, 10'h020, 3'b000, 32'h0};
    vec[2]  = '{3'b100, 3'b100, 10'h030, 3'b001, 32'hA000_0010};
    vec[3]  = '{3'b001, 3'b001, 10'h010, 3'b010, 32'hA000_0020};
    vec[4]  = '{3'b000, 3'b000, 10'h000, 3'b100, 32'hA000_0030};
    vec[5]  = '{3'b000, 3'b000, 10'h000, 3'b001, 32'hA000_0010};
    vec[6]  = '{3'b010, 3'b010, 10'h020, 3'b000, 32'h0};
    vec[7]  = '{3'b001, 3'b001, 10'h010, 3'b000, 32'h0};
    vec[8]  = '{3'b101, 3'b100, 10'h030, 3'b010, 32'hA000_0020};
    vec[9]  = '{3'b001, 3'b001, 10'h010, 3'b001, 32'hA000_0010};
    vec[10] = '{3'b000, 3'b000, 10'h000, 3'b100, 32'hA000_0030};
    vec[11] = '{3'b000, 3'b000, 10'h000, 3'b001, 32'hA000_0010};

    clear_ports();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset rsp_valid", 64'(bus.rsp_valid_o), 64'(3'b000));
    check("reset idle ready", 64'(bus.req_ready_o), 64'(3'b000));
    check("reset idle sram_req", 64'(bus.sram_req_o), 64'(1'b0));
    next_cycle();
    s_valid[0] = 1'b1; s_addr[0] = 10'h010; drive();
    @(negedge clk);
    check("reset comb ready", 64'(bus.req_ready_o), 64'(3'b001));
    check("reset comb sram_req", 64'(bus.sram_req_o), 64'(1'b1));
    check("reset rsp_valid held", 64'(bus.rsp_valid_o), 64'(3'b000));
    next_cycle();
    clear_ports();
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      s_valid = vec[v].valid;
      for (int i = 0; i < int'(NR); i++) s_addr[i] = AW'(16 * (i + 1));
      drive();
      @(negedge clk);
      check($sformatf("vec%0d ready", v), 64'(bus.req_ready_o), 64'(vec[v].exp_ready));
      check($sformatf("vec%0d sram_req", v), 64'(bus.sram_req_o), 64'(|vec[v].valid));
      check($sformatf("vec%0d sram_we", v), 64'(bus.sram_we_o), 64'(1'b0));
      check($sformatf("vec%0d sram_addr", v), 64'(bus.sram_addr_o), 64'(vec[v].exp_addr));
      check($sformatf("vec%0d rsp_valid", v), 64'(bus.rsp_valid_o), 64'(vec[v].exp_rsp));
      if (vec[v].exp_rsp != '0)
        check($sformatf("vec%0d rsp_rdata", v), 64'(bus.rsp_rdata_o), 64'(vec[v].exp_rdata));
      next_cycle();
    end

    // Write from port 1, then read-back from port 2 of the same word.
    clear_ports();
    s_valid[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 10'h005;
    s_wdata[1] = 32'hDEAD_BEEF; s_be[1] = 4'hF;
    drive();
    @(negedge clk);
    check("wr ready", 64'(bus.req_ready_o), 64'(3'b010));
    check("wr sram_we", 64'(bus.sram_we_o), 64'(1'b1));
    check("wr sram_addr", 64'(bus.sram_addr_o), 64'(10'h005));
    check("wr sram_wdata", 64'(bus.sram_wdata_o), 64'(32'hDEAD_BEEF));
    check("wr sram_be", 64'(bus.sram_be_o), 64'(4'hF));
    next_cycle();
    clear_ports();
    s_valid[2] = 1'b1; s_addr[2] = 10'h005; drive();
    @(negedge clk);
    check("rd ready", 64'(bus.req_ready_o), 64'(3'b100));
    check("rd sram_we", 64'(bus.sram_we_o), 64'(1'b0));
    check("rd sram_addr", 64'(bus.sram_addr_o), 64'(10'h005));
    next_cycle();
    clear_ports();
    @(negedge clk);
    check("no write response", 64'(bus.rsp_valid_o), 64'(3'b000));
    next_cycle();
    @(negedge clk);
    check("raw rsp_valid", 64'(bus.rsp_valid_o), 64'(3'b100));
    check("raw rsp_rdata", 64'(bus.rsp_rdata_o), 64'(32'hDEAD_BEEF));
    next_cycle();

    // Read in flight when reset hits: dropped, and the pointer returns to port 0.
    s_valid[0] = 1'b1; s_addr[0] = 10'h040; drive();
    @(negedge clk);
    check("inflight ready", 64'(bus.req_ready_o), 64'(3'b001));
    next_cycle();
    clear_ports();
    rst_n = 1'b0;
    @(negedge clk);
    check("inflight reset rsp", 64'(bus.rsp_valid_o), 64'(3'b000));
    next_cycle();
    rst_n = 1'b1;
    s_valid = 3'b011; s_addr[0] = 10'h040; s_addr[1] = 10'h050; drive();
    @(negedge clk);
    check("inflight dropped", 64'(bus.rsp_valid_o), 64'(3'b000));
    check("post-reset ready", 64'(bus.req_ready_o), 64'(3'b001));
    next_cycle();
    s_valid = 3'b010; drive();
    @(negedge clk);
    check("post-reset ready2", 64'(bus.req_ready_o), 64'(3'b010));
    next_cycle();
    clear_ports();
    @(negedge clk);
    check("post-reset rsp0", 64'(bus.rsp_valid_o), 64'(3'b001));
    check("post-reset rdata0", 64'(bus.rsp_rdata_o), 64'(32'hA000_0040));
    next_cycle();
    @(negedge clk);
    check("post-reset rsp1", 64'(bus.rsp_valid_o), 64'(3'b010));
    check("post-reset rdata1", 64'(bus.rsp_rdata_o), 64'(32'hA000_0050));
    next_cycle();

    // Random traffic in 0x100..0x10F, untouched by the directed part.
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) ref_mem[a] = pattern(256 + a);
    ptr  = 0;
    cyc  = 0;
    held = '0;
    exp_q.delete();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < int'(NR); i++) begin
        if (!held[i]) begin
          s_valid[i] = ($urandom_range(0, 99) < 55);
          s_we[i]    = ($urandom_range(0, 2) == 0);
          s_addr[i]  = AW'(256 + $urandom_range(0, 15));
          s_wdata[i] = $urandom;
          s_be[i]    = BW'($urandom_range(0, 15));
        end
      end
      drive();

      g = -1;
      for (int k = 0; k < int'(NR); k++) begin
        j = (ptr + k) % int'(NR);
        if (g < 0 && s_valid[j]) g = j;
      end
      exp_ready = onehot(g);
      exp_rsp   = (exp_q.size() > 0 && exp_q[0].due == cyc) ? onehot(exp_q[0].idx) : '0;

      @(negedge clk);
      check($sformatf("rnd%0d ready", n), 64'(bus.req_ready_o), 64'(exp_ready));
      check($sformatf("rnd%0d sram_req", n), 64'(bus.sram_req_o), 64'(|s_valid));
      check($sformatf("rnd%0d sram_we", n), 64'(bus.sram_we_o), 64'((g >= 0) ? s_we[g] : 1'b0));
      check($sformatf("rnd%0d sram_addr", n), 64'(bus.sram_addr_o), 64'((g >= 0) ? s_addr[g] : '0));
      check($sformatf("rnd%0d sram_wdata", n), 64'(bus.sram_wdata_o),
            64'((g >= 0) ? s_wdata[g] : '0));
      check($sformatf("rnd%0d sram_be", n), 64'(bus.sram_be_o), 64'((g >= 0) ? s_be[g] : '0));
      check($sformatf("rnd%0d rsp_valid", n), 64'(bus.rsp_valid_o), 64'(exp_rsp));
      if (exp_rsp != '0)
        check($sformatf("rnd%0d rsp_rdata", n), 64'(bus.rsp_rdata_o), 64'(exp_q[0].data));
      next_cycle();

      if (g >= 0) begin
        ra = int'(s_addr[g]) - 256;
        if (!s_we[g]) begin
          exp_q.push_back('{cyc + int'(LAT), g, ref_mem[ra]});
        end else begin
          for (int b = 0; b < int'(BW); b++)
            if (s_be[g][b]) ref_mem[ra][b*8 +: 8] = s_wdata[g][b*8 +: 8];
        end
        ptr = (g + 1) % int'(NR);
      end
      for (int i = 0; i < int'(NR); i++) held[i] = s_valid[i] && (i != g);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
      cyc++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
